// File: rtl/table_access_arbiter.sv
// Round-robin arbiter sharing a 2-write / 2-read table among NUM_REQ requesters.
// Grants are combinational; the table command is registered; responses are routed back by owner id.
module table_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [1:0]                tbl_wr_en,
    output logic [2*IDX_W-1:0]        tbl_index_wr,
    output logic [2*DATA_W-1:0]       tbl_data_wr,
    output logic                      tbl_rd_en,
    output logic [2*IDX_W-1:0]        tbl_index_rd,
    input  logic [2*DATA_W-1:0]       tbl_data_rd
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]             r_rr_ptr;
    logic [PTR_W-1:0]             w_rr_next;
    logic [NUM_REQ-1:0]           w_gnt;
    logic [1:0]                   w_wr_vld;
    logic [1:0][IDX_W-1:0]        w_wr_idx;
    logic [1:0][DATA_W-1:0]       w_wr_data;
    logic [1:0]                   w_rd_vld;
    logic [1:0][IDX_W-1:0]        w_rd_idx;
    logic [1:0][PTR_W-1:0]        w_rd_own;

    logic [1:0]                   r_wr_en;
    logic [1:0][IDX_W-1:0]        r_wr_idx;
    logic [1:0][DATA_W-1:0]       r_wr_data;
    logic                         r_rd_en;
    logic [1:0][IDX_W-1:0]        r_rd_idx;
    logic [1:0]                   r_p1_vld;
    logic [1:0][PTR_W-1:0]        r_p1_own;
    logic [1:0]                   r_p2_vld;
    logic [1:0][PTR_W-1:0]        r_p2_own;

    // Writes are scanned first so a read can be blocked by a write granted later in scan order.
    always_comb begin
        int k;
        int last;
        logic [IDX_W-1:0] idx;
        w_gnt     = '0;
        w_wr_vld  = '0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        w_rd_vld  = '0;
        w_rd_idx  = '0;
        w_rd_own  = '0;
        w_rr_next = r_rr_ptr;
        k         = 0;
        last      = -1;
        idx       = '0;

        for (int j = 0; j < NUM_REQ; j++) begin
            k = int'(r_rr_ptr) + j;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            idx = req_index[k*IDX_W +: IDX_W];
            if (req_valid[k] && req_we[k]) begin
                if (!w_wr_vld[0]) begin
                    w_wr_vld[0]  = 1'b1;
                    w_wr_idx[0]  = idx;
                    w_wr_data[0] = req_wdata[k*DATA_W +: DATA_W];
                    w_gnt[k]     = 1'b1;
                    last         = j;
                end else if (!w_wr_vld[1] && idx != w_wr_idx[0]) begin
                    w_wr_vld[1]  = 1'b1;
                    w_wr_idx[1]  = idx;
                    w_wr_data[1] = req_wdata[k*DATA_W +: DATA_W];
                    w_gnt[k]     = 1'b1;
                    last         = j;
                end
            end
        end

        for (int j = 0; j < NUM_REQ; j++) begin
            k = int'(r_rr_ptr) + j;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            idx = req_index[k*IDX_W +: IDX_W];
            if (req_valid[k] && !req_we[k] &&
                !(w_wr_vld[0] && idx == w_wr_idx[0]) &&
                !(w_wr_vld[1] && idx == w_wr_idx[1])) begin
                if (!w_rd_vld[0]) begin
                    w_rd_vld[0] = 1'b1;
                    w_rd_idx[0] = idx;
                    w_rd_own[0] = PTR_W'(k);
                    w_gnt[k]    = 1'b1;
                    if (j > last) last = j;
                end else if (!w_rd_vld[1]) begin
                    w_rd_vld[1] = 1'b1;
                    w_rd_idx[1] = idx;
                    w_rd_own[1] = PTR_W'(k);
                    w_gnt[k]    = 1'b1;
                    if (j > last) last = j;
                end
            end
        end

        if (last >= 0) begin
            k = int'(r_rr_ptr) + last + 1;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            w_rr_next = PTR_W'(k);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= '0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_rd_en   <= 1'b0;
            r_rd_idx  <= '0;
            r_p1_vld  <= '0;
            r_p1_own  <= '0;
            r_p2_vld  <= '0;
            r_p2_own  <= '0;
        end else begin
            r_rr_ptr  <= w_rr_next;
            r_wr_en   <= w_wr_vld;
            r_wr_idx  <= w_wr_idx;
            r_wr_data <= w_wr_data;
            r_rd_en   <= |w_rd_vld;
            r_rd_idx  <= w_rd_idx;
            r_p1_vld  <= w_rd_vld;
            r_p1_own  <= w_rd_own;
            r_p2_vld  <= r_p1_vld;
            r_p2_own  <= r_p1_own;
        end
    end

    // Read data arrives while stage 2 holds the owners of the slots it belongs to.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int s = 0; s < 2; s++) begin
            if (r_p2_vld[s]) begin
                rsp_valid[r_p2_own[s]]                      = 1'b1;
                rsp_data[int'(r_p2_own[s])*DATA_W +: DATA_W] = tbl_data_rd[s*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready    = rst ? w_gnt : '0;
    assign tbl_wr_en    = r_wr_en;
    assign tbl_index_wr = r_wr_idx;
    assign tbl_data_wr  = r_wr_data;
    assign tbl_rd_en    = r_rd_en;
    assign tbl_index_rd = r_rd_idx;

endmodule

// File: tb/tb_table_access_arbiter.sv
// Bench for table_access_arbiter: a table emulation plus a queue-based reference model of
// the grant rules, with directed scenarios followed by randomized traffic.
module tb_table_access_arbiter;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
    logic [N*IW-1:0]   req_index;
    logic [N*DW-1:0]   req_wdata, rsp_data;
    logic [1:0]        tbl_wr_en;
    logic [2*IW-1:0]   tbl_index_wr, tbl_index_rd;
    logic [2*DW-1:0]   tbl_data_wr, tbl_data_rd;
    logic              tbl_rd_en;

    always #5 clk = ~clk;

    table_access_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_index(req_index), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tbl_wr_en(tbl_wr_en), .tbl_index_wr(tbl_index_wr), .tbl_data_wr(tbl_data_wr),
        .tbl_rd_en(tbl_rd_en), .tbl_index_rd(tbl_index_rd), .tbl_data_rd(tbl_data_rd)
    );

    // Table emulation: one-cycle read latency, read-old on a same-edge write.
    logic [DW-1:0] tbl_mem [32];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) tbl_mem[i] <= DW'(i*37 + 5);
            mem_ready   <= 1'b1;
            tbl_data_rd <= '0;
        end else begin
            if (tbl_rd_en)
                tbl_data_rd <= {tbl_mem[tbl_index_rd[2*IW-1:IW]], tbl_mem[tbl_index_rd[IW-1:0]]};
            for (int k = 0; k < 2; k++)
                if (tbl_wr_en[k]) tbl_mem[tbl_index_wr[k*IW +: IW]] <= tbl_data_wr[k*DW +: DW];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0]   ref_mem [32];
    int              m_rr;
    bit              p_v [N];
    bit              p_we [N];
    logic [IW-1:0]   p_idx [N];
    logic [DW-1:0]   p_d [N];
    logic [1:0]      e_wen;
    logic [2*IW-1:0] e_widx, e_ridx;
    logic [2*DW-1:0] e_wdata;
    logic            e_ren;
    logic [N-1:0]    e_rv_d1, e_rv_d2;
    logic [N*DW-1:0] e_rd_d1, e_rd_d2;
    logic [N-1:0]    last_rdy, last_rsp;
    logic [N*DW-1:0] last_rspd;

    function automatic bit in_list(input logic [IW-1:0] q[$], input logic [IW-1:0] v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [IW-1:0] pick_idx();
        int v;
        v = $urandom_range(5, 0);
        return (v == 5) ? IW'(31) : IW'(v);
    endfunction

    function automatic bit any_pending();
        for (int r = 0; r < N; r++) if (p_v[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_expect();
        e_wen = '0; e_widx = '0; e_wdata = '0; e_ren = 1'b0; e_ridx = '0;
        e_rv_d1 = '0; e_rv_d2 = '0; e_rd_d1 = '0; e_rd_d2 = '0;
    endtask

    task automatic set_req(input int r, input bit we, input logic [IW-1:0] idx, input logic [DW-1:0] d);
        p_v[r] = 1'b1; p_we[r] = we; p_idx[r] = idx; p_d[r] = d;
    endtask

    task automatic step(input bit gen);
        logic [N-1:0]    g, rv_new;
        logic [N*DW-1:0] rd_new;
        logic [IW-1:0]   wl[$];
        logic [1:0]      wen;
        logic [2*IW-1:0] widx, ridx;
        logic [2*DW-1:0] wdat;
        int nr, last, r;
        @(negedge clk);
        chk("tbl_wr_en", 64'(tbl_wr_en), 64'(e_wen));
        chk("tbl_index_wr", 64'(tbl_index_wr), 64'(e_widx));
        chk("tbl_data_wr", 64'(tbl_data_wr), 64'(e_wdata));
        chk("tbl_rd_en", 64'(tbl_rd_en), 64'(e_ren));
        chk("tbl_index_rd", 64'(tbl_index_rd), 64'(e_ridx));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv_d2));
        for (int q = 0; q < N; q++)
            if (e_rv_d2[q]) chk("rsp_data", 64'(rsp_data[q*DW +: DW]), 64'(e_rd_d2[q*DW +: DW]));
        last_rsp  = rsp_valid;
        last_rspd = rsp_data;
        // commands issued this cycle land at its closing edge
        for (int k = 0; k < 2; k++)
            if (e_wen[k]) ref_mem[e_widx[k*IW +: IW]] = e_wdata[k*DW +: DW];
        if (gen)
            for (int q = 0; q < N; q++)
                if (!p_v[q] && $urandom_range(9, 0) < 6)
                    set_req(q, 1'($urandom_range(1, 0)), pick_idx(), DW'($urandom));
        for (int q = 0; q < N; q++) begin
            req_valid[q]          = p_v[q];
            req_we[q]             = p_we[q];
            req_index[q*IW +: IW] = p_idx[q];
            req_wdata[q*DW +: DW] = p_d[q];
        end
        #1;
        g = '0; rv_new = '0; rd_new = '0; wen = '0; widx = '0; ridx = '0; wdat = '0;
        nr = 0; last = -1;
        for (int j = 0; j < N; j++) begin
            r = (m_rr + j) % N;
            if (p_v[r] && p_we[r] && wl.size() < 2 && !in_list(wl, p_idx[r])) begin
                widx[wl.size()*IW +: IW] = p_idx[r];
                wdat[wl.size()*DW +: DW] = p_d[r];
                wen[wl.size()] = 1'b1;
                wl.push_back(p_idx[r]);
                g[r] = 1'b1;
                last = j;
            end
        end
        for (int j = 0; j < N; j++) begin
            r = (m_rr + j) % N;
            if (p_v[r] && !p_we[r] && nr < 2 && !in_list(wl, p_idx[r])) begin
                ridx[nr*IW +: IW] = p_idx[r];
                nr++;
                g[r] = 1'b1;
                rv_new[r] = 1'b1;
                rd_new[r*DW +: DW] = ref_mem[p_idx[r]];
                if (j > last) last = j;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(g));
        last_rdy = req_ready;
        if (last >= 0) m_rr = (m_rr + last + 1) % N;
        for (int q = 0; q < N; q++) if (g[q]) p_v[q] = 1'b0;
        e_wen = wen; e_widx = widx; e_wdata = wdat; e_ren = (nr > 0); e_ridx = ridx;
        e_rv_d2 = e_rv_d1; e_rd_d2 = e_rd_d1;
        e_rv_d1 = rv_new;  e_rd_d1 = rd_new;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_wr_en"}, 64'(tbl_wr_en), 64'd0);
        chk({tag, "_wr_idx"}, 64'(tbl_index_wr), 64'd0);
        chk({tag, "_rd_en"}, 64'(tbl_rd_en), 64'd0);
        chk({tag, "_rd_idx"}, 64'(tbl_index_rd), 64'd0);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        req_valid = '0;
        clear_expect();
        m_rr = 0;
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        req_valid = '0; req_we = '0; req_index = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i*37 + 5);
        for (int q = 0; q < N; q++) begin p_v[q] = 1'b0; p_we[q] = 1'b0; p_idx[q] = '0; p_d[q] = '0; end
        m_rr = 0;
        clear_expect();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // four writers: two now, the other two next cycle
        set_req(0, 1, 5'd1, 8'h11); set_req(1, 1, 5'd2, 8'h22);
        set_req(2, 1, 5'd3, 8'h33); set_req(3, 1, 5'd4, 8'h44);
        step(0); chk("four_wr_c0", 64'(last_rdy), 64'b0011);
        step(0); chk("four_wr_c1", 64'(last_rdy), 64'b1100);
        step(0);

        // write/write hazard on idx 7, then read it back
        set_req(0, 1, 5'd7, 8'hA5); set_req(1, 1, 5'd7, 8'h5A);
        step(0); chk("ww_c0", 64'(last_rdy), 64'b0001);
        step(0); chk("ww_c1", 64'(last_rdy), 64'b0010);
        set_req(2, 0, 5'd7, 8'h00);
        step(0); step(0); step(0);
        chk("ww_rsp", 64'(last_rspd[2*DW +: DW]), 64'h5A);

        // read/write hazard on idx 9
        set_req(0, 1, 5'd9, 8'hC3); set_req(2, 0, 5'd9, 8'h00);
        step(0); chk("rw_c0", 64'(last_rdy), 64'b0001);
        step(0); chk("rw_c1", 64'(last_rdy), 64'b0100);
        step(0); step(0);
        chk("rw_rsp_v", 64'(last_rsp), 64'b0100);
        chk("rw_rsp_d", 64'(last_rspd[2*DW +: DW]), 64'hC3);

        // dual read of index 0 and index 31
        set_req(0, 1, 5'd0, 8'h01); set_req(1, 1, 5'd31, 8'hFE);
        step(0);
        set_req(1, 0, 5'd0, 8'h00); set_req(3, 0, 5'd31, 8'h00);
        step(0); chk("dual_rdy", 64'(last_rdy), 64'b1010);
        step(0); step(0);
        chk("dual_rsp_v", 64'(last_rsp), 64'b1010);
        chk("dual_d1", 64'(last_rspd[1*DW +: DW]), 64'h01);
        chk("dual_d3", 64'(last_rspd[3*DW +: DW]), 64'hFE);

        // mixed full load
        set_req(0, 1, 5'd10, 8'h10); set_req(1, 1, 5'd11, 8'h20);
        set_req(2, 0, 5'd12, 8'h00); set_req(3, 0, 5'd13, 8'h00);
        step(0); chk("mixed_rdy", 64'(last_rdy), 64'b1111);
        step(0); step(0);

        // reset while a read is in flight; pointer must restart at requester 0
        set_req(0, 0, 5'd3, 8'h00);
        step(0);
        do_reset_mid();
        set_req(1, 1, 5'd5, 8'h77); set_req(0, 1, 5'd5, 8'h66);
        step(0); chk("post_rst_rr", 64'(last_rdy), 64'b0001);
        step(0); step(0); step(0);

        repeat (400) step(1);

        guard = 0;
        while (any_pending() && guard < 40) begin
            step(0);
            guard++;
        end
        chk("drain", 64'(any_pending()), 64'd0);
        step(0); step(0); step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/table_access_arbiter.md
# table_access_arbiter

Shares the table's two write ports and single dual-index read port among NUM_REQ independent requesters. It sits between client logic and the 32-entry x 8-bit table. Each cycle it issues up to two writes and two reads with round-robin fairness, blocks same-cycle index hazards, and routes read data back to the owning requester. All table-side outputs are registered.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- IDX_W, 5: table index width
- DATA_W, 8: table entry width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_index  input  NUM_REQ*IDX_W  per-requester index, requester i at slice [i*IDX_W +: IDX_W]
- req_wdata  input  NUM_REQ*DATA_W  per-requester write data
- req_ready  output  NUM_REQ  grant; handshake = req_valid & req_ready
- rsp_valid  output  NUM_REQ  read data valid for requester i
- rsp_data  output  NUM_REQ*DATA_W  read data
- tbl_wr_en  output  2  write-port enables
- tbl_index_wr  output  2*IDX_W  write indices, port k at [k*IDX_W +: IDX_W]
- tbl_data_wr  output  2*DATA_W  write data
- tbl_rd_en  output  1  read enable covering both read slots
- tbl_index_rd  output  2*IDX_W  read indices
- tbl_data_rd  input  2*DATA_W  table read data, valid 1 cycle after tbl_rd_en is sampled

## Operation
- Arbitration is combinational from req_* and the registered rr_ptr. Scan order: rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Scan walks requesters in order and keeps two slot counters:
  - Write: grant if write slots < 2 and the index differs from writes already granted this cycle. Same-index write → deferred; first in scan order wins.
  - Read: grant if read slots < 2 and the index matches no write granted this cycle, including writes granted later in the scan. Reads of the same index by two requesters are both granted.
- Any number of requesters may be granted per cycle, up to 2 writes plus 2 reads.
- Write slots and read slots are filled in scan order: first granted → slot 0, second → slot 1.
- rr_ptr update: set to (last granted requester in scan order + 1) mod NUM_REQ. Unchanged if nothing is granted.
- Registered table command for cycle T+1:
  - tbl_wr_en[k] = 1 for each filled write slot.
  - tbl_rd_en = 1 if any read slot is filled.
  - Unused slot indices and data are driven 0.
- Read owner tracking: a 2-stage pipeline of {valid, owner id} per read slot.
  - In the response cycle, rsp_valid[owner] = 1 and rsp_data[owner] = that slot's tbl_data_rd slice, combinational from tbl_data_rd.
  - Both slots may target different requesters.
- Responses have no back-pressure; requesters must accept them.
- A requester may hold a new request the cycle after its handshake. Reads are pipelined with no outstanding limit.

## Timing
- Handshake in cycle T → table command on outputs during T+1 → table data and rsp_valid during T+2.
- Read latency is 2 cycles from handshake. Writes land at the end of T+1.
- A read handshaken in T+1 or later returns data written by a write handshaken in T.
- Reset (rst = 0), asynchronous:
  - All outputs go to 0, including req_ready, tbl_* and rsp_*.
  - rr_ptr = 0 and owner pipeline cleared.
  - Reads in flight are dropped: no rsp_valid after reset.
- Reset release: grants may appear in the first cycle with rst = 1.
- Boundaries:
  - Index 0 and index 31 are treated identically.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A third writer or reader in the same cycle waits and wins the next cycle, because rr_ptr has passed the granted ones.

## Test plan
- Reset mid-traffic: req0 reads idx 3 at T, rst low at T+1 → all outputs 0 immediately, no rsp_valid at T+2; after release, rr_ptr = 0.
- Four writers in one cycle (idx 1, 2, 3, 4; data 0x11, 0x22, 0x33, 0x44) → T: req0 and req1 granted, tbl_wr_en = 2'b11 at T+1; T+1: req2 and req3 granted. Order rotates fairly over 8 cycles.
- Write/write hazard: req0 and req1 both write idx 7 (0xA5, 0x5A) → only req0 granted; req1 granted next cycle; a later read of idx 7 returns 0x5A.
- Read/write hazard: req2 reads idx 9 while req0 writes idx 9 = 0xC3 → read deferred one cycle and returns 0xC3 with rsp_valid[2] 2 cycles after its grant.
- Dual read: req1 reads idx 0, req3 reads idx 31 (table holds 0x01 and 0xFE) → single tbl_rd_en pulse; at T+2, rsp_valid = 4'b1010, rsp_data for req1 = 0x01, for req3 = 0xFE.
- Mixed full load: 2 writes and 2 reads to distinct indices in one cycle → all four req_ready high, with both write and read commands in the same T+1.
